// File: rtl/input_line_writer_if.sv
// Stream input and line-bank write port of the input line writer.
// master: the writer (accepts the stream, drives the bank port); slave: source / bank side.
interface input_line_writer_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 9,
  parameter int NUM_LINES  = 6
) ();
  logic                  s_valid;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_ready;
  logic [NUM_LINES-1:0]  en_wr;
  logic [ADDR_WIDTH-1:0] addr_wr;
  logic [DATA_WIDTH-1:0] data_wr;

  modport master (
    input  s_valid, s_data,
    output s_ready, en_wr, addr_wr, data_wr
  );

  modport slave (
    output s_valid, s_data,
    input  s_ready, en_wr, addr_wr, data_wr
  );
endinterface

// File: rtl/input_line_writer.sv
// Write-side controller of the 6-line input line buffer: rotates banks, tracks occupancy.
// Optional macro LINE_WR_STALL_CNT_EN adds the stall_cycles_o back-pressure counter.
module input_line_writer #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 9,
  parameter int NUM_LINES  = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [9:0]  cfg_row_words_i,
  input  logic [10:0] cfg_rows_i,
  input  logic        line_release_i,
  input_line_writer_if.master bus,
  output logic [2:0]  lines_avail_o,
  output logic        row_done_o,
  output logic        frame_done_o,
  output logic        busy_o,
  output logic        err_release_o
`ifdef LINE_WR_STALL_CNT_EN
  , output logic [31:0] stall_cycles_o
`endif
);

  localparam logic [2:0] FULL     = 3'(NUM_LINES);
  localparam logic [2:0] LAST_BNK = 3'(NUM_LINES - 1);

  typedef enum logic [1:0] {IDLE, WRITE, WAIT, DONE} state_t;

  state_t                state_q, state_d;
  logic [9:0]            cfg_words_q, cfg_words_d;
  logic [10:0]           cfg_rows_q, cfg_rows_d;
  logic [ADDR_WIDTH-1:0] col_q, col_d;
  logic [10:0]           row_q, row_d;
  logic [2:0]            bank_q, bank_d;
  logic [2:0]            occ_q, occ_d;
  logic [2:0]            avail_q, avail_d;
  logic                  err_q, err_d;
  logic [NUM_LINES-1:0]  en_q, en_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  row_done_q, row_done_d;

  logic s_ready, acc, last_col, last_row, last_acc, row_first, rel_ok, cfg_ok, start_ok;

`ifdef LINE_WR_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;
`endif

  always_comb begin
    state_d     = state_q;
    cfg_words_d = cfg_words_q;
    cfg_rows_d  = cfg_rows_q;
    col_d       = col_q;
    row_d       = row_q;
    bank_d      = bank_q;
    err_d       = err_q;
    en_d        = '0;
    addr_d      = addr_q;
    data_d      = data_q;
    row_done_d  = 1'b0;

    // A row may only begin when a free line exists; the tail of a row is never blocked.
    s_ready   = (state_q == WRITE) && !((col_q == '0) && (occ_q == FULL));
    acc       = bus.s_valid && s_ready;
    last_col  = (10'(col_q) == (cfg_words_q - 10'd1));
    last_row  = (row_q == (cfg_rows_q - 11'd1));
    row_first = acc && (col_q == '0);
    last_acc  = acc && last_col;
    rel_ok    = line_release_i && (avail_q != 3'd0);
    cfg_ok    = (cfg_row_words_i != 10'd0) && (cfg_row_words_i <= 10'd512) &&
                (cfg_rows_i != 11'd0);
    start_ok  = (state_q == IDLE) && start_i && cfg_ok;

    if (line_release_i && (avail_q == 3'd0)) err_d = 1'b1;

    occ_d   = occ_q + {2'b00, row_first} - {2'b00, rel_ok};
    avail_d = avail_q + {2'b00, last_acc} - {2'b00, rel_ok};

    if (acc) begin
      en_d[bank_q] = 1'b1;
      addr_d       = col_q;
      data_d       = bus.s_data;
      if (last_col) begin
        col_d      = '0;
        bank_d     = (bank_q == LAST_BNK) ? 3'd0 : bank_q + 3'd1;
        row_d      = row_q + 11'd1;
        row_done_d = 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_d     = WRITE;
          cfg_words_d = cfg_row_words_i;
          cfg_rows_d  = cfg_rows_i;
          col_d       = '0;
          row_d       = '0;
          bank_d      = '0;
          occ_d       = '0;
          avail_d     = '0;
          err_d       = 1'b0;
        end
      end
      WRITE: begin
        if (last_acc && last_row)                     state_d = DONE;
        else if (last_acc && (occ_d == FULL))         state_d = WAIT;
        else if ((col_q == '0) && (occ_q == FULL))    state_d = WAIT;
      end
      WAIT: begin
        if (occ_q < FULL) state_d = WRITE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

`ifdef LINE_WR_STALL_CNT_EN
    stall_d = stall_q;
    if (start_ok)
      stall_d = '0;
    else if ((state_q != IDLE) && bus.s_valid && !s_ready && (stall_q != 32'hFFFF_FFFF))
      stall_d = stall_q + 32'd1;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cfg_words_q <= '0;
      cfg_rows_q  <= '0;
      col_q       <= '0;
      row_q       <= '0;
      bank_q      <= '0;
      occ_q       <= '0;
      avail_q     <= '0;
      err_q       <= 1'b0;
      en_q        <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      row_done_q  <= 1'b0;
`ifdef LINE_WR_STALL_CNT_EN
      stall_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cfg_words_q <= cfg_words_d;
      cfg_rows_q  <= cfg_rows_d;
      col_q       <= col_d;
      row_q       <= row_d;
      bank_q      <= bank_d;
      occ_q       <= occ_d;
      avail_q     <= avail_d;
      err_q       <= err_d;
      en_q        <= en_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      row_done_q  <= row_done_d;
`ifdef LINE_WR_STALL_CNT_EN
      stall_q     <= stall_d;
`endif
    end
  end

  assign bus.s_ready    = s_ready;
  assign bus.en_wr      = en_q;
  assign bus.addr_wr    = addr_q;
  assign bus.data_wr    = data_q;
  assign lines_avail_o  = avail_q;
  assign row_done_o     = row_done_q;
  assign frame_done_o   = (state_q == DONE);
  assign busy_o         = (state_q != IDLE);
  assign err_release_o  = err_q;
`ifdef LINE_WR_STALL_CNT_EN
  assign stall_cycles_o = stall_q;
`endif

endmodule

// File: tb/tb_input_line_writer.sv
// Randomised scoreboard bench for input_line_writer: expected writes come from
// word-index arithmetic (row = k / W, col = k % W, bank = row % 6) and a line-count model.
module tb_input_line_writer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        line_release = 1'b0;
  logic [9:0]  cfg_w = '0;
  logic [10:0] cfg_r = '0;
  logic [2:0]  lines_avail;
  logic        row_done, frame_done, busy, err_release;
`ifdef LINE_WR_STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif

  input_line_writer_if #(.DATA_WIDTH(64), .ADDR_WIDTH(9), .NUM_LINES(6)) bus ();

  input_line_writer #(.DATA_WIDTH(64), .ADDR_WIDTH(9), .NUM_LINES(6)) dut (
    .clk(clk), .rst(rst), .start_i(start), .cfg_row_words_i(cfg_w), .cfg_rows_i(cfg_r),
    .line_release_i(line_release), .bus(bus), .lines_avail_o(lines_avail),
    .row_done_o(row_done), .frame_done_o(frame_done), .busy_o(busy),
    .err_release_o(err_release)
`ifdef LINE_WR_STALL_CNT_EN
    , .stall_cycles_o(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  en;
    logic [8:0]  addr;
    logic [63:0] data;
    logic        rd;
  } exp_t;

  exp_t q[$];
  int   checks = 0, errors = 0;
  int   k = 0, mw = 1, mr = 1;
  int   exp_avail = 0;
  logic exp_err = 1'b0;
  int   exp_frames = 0, got_frames = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // One clock: observe handshake at negedge, commit the model at posedge, return at posedge+1.
  task automatic step();
    logic acc;
    int   nav, col, row;
    logic nerr;
    @(negedge clk);
    acc  = bus.s_valid && bus.s_ready && !rst;
    nav  = exp_avail;
    nerr = exp_err;
    if (rst) begin
      nav = 0; nerr = 1'b0; k = 0;
    end else if (start && cfg_w >= 10'd1 && cfg_w <= 10'd512 && cfg_r >= 11'd1) begin
      nav = 0; nerr = 1'b0; k = 0; mw = int'(cfg_w); mr = int'(cfg_r);
    end else begin
      col = k % mw;
      row = k / mw;
      if (acc && col == 0) chk("ready_when_full", (exp_avail < 6), 1);
      if (line_release) begin
        if (nav == 0) nerr = 1'b1;
        else nav--;
      end
      if (acc) begin
        q.push_back('{en: 6'b1 << (row % 6), addr: 9'(col), data: bus.s_data,
                      rd: (col == mw - 1)});
        if (col == mw - 1) nav++;
        k++;
        if (k == mw * mr) exp_frames++;
      end
    end
    @(posedge clk);
    exp_avail = nav;
    exp_err   = nerr;
    if (rst) q.delete();
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (bus.en_wr != '0) begin
        if (q.size() == 0) begin
          chk("unexpected_write", {bus.en_wr, bus.addr_wr}, 0);
        end else begin
          e = q.pop_front();
          chk("en_wr", bus.en_wr, e.en);
          chk("addr_wr", bus.addr_wr, e.addr);
          chk("data_wr", bus.data_wr, e.data);
          chk("row_done", row_done, e.rd);
        end
      end else begin
        chk("row_done_idle", row_done, 0);
      end
      chk("lines_avail", lines_avail, exp_avail);
      chk("err_release", err_release, exp_err);
      if (!busy) chk("ready_not_busy", bus.s_ready, 0);
      if (frame_done) got_frames++;
    end
  end

  // mode 0: random valid and random releases; mode 1: valid held, release only after a long stall.
  task automatic run_frame(input int w, input int r, input int rate, input int mode);
    int n, stall, prevk;
    cfg_w = 10'(w); cfg_r = 11'(r);
    start = 1'b1; bus.s_valid = 1'b0; line_release = 1'b0;
    step();
    start = 1'b0;
    n = 0; stall = 0;
    while (k < w * r && n < 20000) begin
      bus.s_valid  = (mode == 1) ? 1'b1 : (($urandom % 4) != 0);
      bus.s_data   = {$urandom, $urandom};
      if (mode == 0) line_release = (rate != 0) && (($urandom % rate) == 0);
      else           line_release = (stall >= 20);
      prevk = k;
      step();
      n++;
      stall = (k == prevk && !line_release) ? stall + 1 : 0;
    end
    chk("frame_budget", (n < 20000), 1);
    bus.s_valid = 1'b0; line_release = 1'b0;
    n = 0;
    while (busy && n < 20) begin step(); n++; end
    chk("frame_idle", busy, 0);
    chk("frame_done_count", got_frames, exp_frames);
    chk("queue_drained", q.size(), 0);
  endtask

  initial begin
    int n;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    repeat (3) step();
    rst = 1'b0;
    chk("rst_en_wr", bus.en_wr, 0);
    chk("rst_addr_wr", bus.addr_wr, 0);
    chk("rst_data_wr", bus.data_wr, 0);
    chk("rst_s_ready", bus.s_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);

    run_frame(4, 1, 0, 1);
    run_frame(8, 7, 0, 1);
    run_frame(5, 3, 3, 0);
    for (int i = 0; i < 6; i++)
      run_frame(1 + int'($urandom % 6), 1 + int'($urandom % 12), 2 + int'($urandom % 9), 0);

    // drain all lines, then release once more with nothing to release
    n = 0;
    while (exp_avail != 0 && n < 10) begin line_release = 1'b1; step(); n++; end
    line_release = 1'b1; step();
    line_release = 1'b0; step(); step();
    chk("err_sticky", err_release, 1);
    chk("avail_after_bad_release", lines_avail, 0);

    // illegal configurations are refused
    cfg_w = 10'd0;   cfg_r = 11'd3; start = 1'b1; step(); start = 1'b0; step();
    chk("cfg_words0_idle", busy, 0);
    cfg_w = 10'd513; cfg_r = 11'd3; start = 1'b1; step(); start = 1'b0; step();
    chk("cfg_words513_idle", busy, 0);
    cfg_w = 10'd4;   cfg_r = 11'd0; start = 1'b1; step(); start = 1'b0; step();
    chk("cfg_rows0_idle", busy, 0);

    // reset in the middle of row 2, column 3
    cfg_w = 10'd6; cfg_r = 11'd5; start = 1'b1; step(); start = 1'b0;
    n = 0;
    while (k < 15 && n < 200) begin
      bus.s_valid = 1'b1; bus.s_data = {$urandom, $urandom}; step(); n++;
    end
    rst = 1'b1; bus.s_valid = 1'b0;
    step();
    rst = 1'b0;
    chk("midrst_en_wr", bus.en_wr, 0);
    chk("midrst_s_ready", bus.s_ready, 0);
    chk("midrst_avail", lines_avail, 0);
    chk("midrst_busy", busy, 0);
    step();
    chk("midrst_no_write", bus.en_wr, 0);
    got_frames = exp_frames;
    run_frame(3, 2, 4, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
